// File: rtl/riscv_v_pkg.sv
// rtl/riscv_v_pkg.sv - shared widths and issue-buffer state encoding for the vector pipe
package riscv_v_pkg;

    localparam int RISCV_V_IMM_WIDTH = 32;

    typedef enum logic [1:0] {
        ISSUE_EMPTY,
        ISSUE_ONE,
        ISSUE_FULL
    } riscv_v_issue_state_e;

endpackage

// File: rtl/riscv_v_sat_counter.sv
// rtl/riscv_v_sat_counter.sv - saturating event counter
// Ports: clk, rst_n (sync, active low), inc (count this cycle), clr (sync clear), cnt (value).
module riscv_v_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {WIDTH{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/riscv_v_issue_buf.sv
// rtl/riscv_v_issue_buf.sv - two-entry skid buffer between vector decode and execute
// Ports: clk, rst_n (sync, active low), flush; in_valid/in_imm/in_uop/in_ready from decode;
// out_valid/out_imm/out_uop/out_ready to execute; stall_cnt only with RISCV_V_ISSUE_BUF_PERF_EN.
module riscv_v_issue_buf
    import riscv_v_pkg::*;
#(
    parameter int IMM_WIDTH = RISCV_V_IMM_WIDTH,
    parameter int UOP_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    input  logic [IMM_WIDTH-1:0] in_imm,
    input  logic [UOP_WIDTH-1:0] in_uop,
    output logic                 in_ready,
    output logic                 out_valid,
    output logic [IMM_WIDTH-1:0] out_imm,
    output logic [UOP_WIDTH-1:0] out_uop,
    input  logic                 out_ready
`ifdef RISCV_V_ISSUE_BUF_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    riscv_v_issue_state_e state;
    logic [IMM_WIDTH-1:0] skid_imm;
    logic [UOP_WIDTH-1:0] skid_uop;
    logic                 accept;
    logic                 retire;

    // Ready depends only on state, so out_ready never reaches the upstream enable combinationally.
    assign out_valid = (state != ISSUE_EMPTY);
    assign in_ready  = (state != ISSUE_FULL);
    assign accept    = in_valid & in_ready;
    assign retire    = out_valid & out_ready;

    // Payloads are only written on load; flush just empties the state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ISSUE_EMPTY;
            out_imm  <= '0;
            out_uop  <= '0;
            skid_imm <= '0;
            skid_uop <= '0;
        end else if (flush) begin
            state <= ISSUE_EMPTY;
        end else begin
            case (state)
                ISSUE_EMPTY: begin
                    if (accept) begin
                        out_imm <= in_imm;
                        out_uop <= in_uop;
                        state   <= ISSUE_ONE;
                    end
                end
                ISSUE_ONE: begin
                    case ({accept, retire})
                        2'b10: begin
                            skid_imm <= in_imm;
                            skid_uop <= in_uop;
                            state    <= ISSUE_FULL;
                        end
                        2'b01: state <= ISSUE_EMPTY;
                        2'b11: begin
                            out_imm <= in_imm;
                            out_uop <= in_uop;
                        end
                        default: ;
                    endcase
                end
                ISSUE_FULL: begin
                    if (retire) begin
                        out_imm <= skid_imm;
                        out_uop <= skid_uop;
                        state   <= ISSUE_ONE;
                    end
                end
                default: state <= ISSUE_EMPTY;
            endcase
        end
    end

`ifdef RISCV_V_ISSUE_BUF_PERF_EN
    riscv_v_sat_counter #(
        .WIDTH (32)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (out_valid & ~out_ready),
        .clr   (1'b0),
        .cnt   (stall_cnt)
    );
`endif

endmodule

// File: tb/tb_riscv_v_issue_buf.sv
// tb/tb_riscv_v_issue_buf.sv - self-checking bench for riscv_v_issue_buf
module tb_riscv_v_issue_buf;
    import riscv_v_pkg::*;

    localparam int IW = RISCV_V_IMM_WIDTH;
    localparam int UW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic [IW-1:0] in_imm;
    logic [UW-1:0] in_uop;
    logic          in_ready;
    logic          out_valid;
    logic [IW-1:0] out_imm;
    logic [UW-1:0] out_uop;
    logic          out_ready;
`ifdef RISCV_V_ISSUE_BUF_PERF_EN
    logic [31:0]   stall_cnt;
`endif

    riscv_v_issue_buf #(
        .IMM_WIDTH (IW),
        .UOP_WIDTH (UW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_imm    (in_imm),
        .in_uop    (in_uop),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_imm   (out_imm),
        .out_uop   (out_uop),
        .out_ready (out_ready)
`ifdef RISCV_V_ISSUE_BUF_PERF_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    logic [IW+UW-1:0] sb[$];
    logic [IW+UW-1:0] sb_e;

    typedef struct {
        logic        iv;
        logic [31:0] imm;
        logic        rdy;
        logic        fl;
        logic        ov;
        logic        ir;
        logic [31:0] eimm;
    } vec_t;

    vec_t vecs[19];

    function automatic logic [UW-1:0] uop_of(input logic [IW-1:0] imm);
        return UW'(imm) ^ UW'(32'hC3C3_0000);
    endfunction

    function automatic vec_t mk(input logic iv, input logic [31:0] imm, input logic rdy,
                                input logic fl, input logic ov, input logic ir,
                                input logic [31:0] eimm);
        vec_t v;
        v.iv = iv; v.imm = imm; v.rdy = rdy; v.fl = fl; v.ov = ov; v.ir = ir; v.eimm = eimm;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Scoreboard: accepted ops are queued before the edge, retired ops popped and compared.
    always @(negedge clk) begin
        if (!rst_n) begin
            sb.delete();
        end else begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected actual imm=%0h expected no op", out_imm);
                end else begin
                    sb_e = sb.pop_front();
                    check("sb_imm", 32'(out_imm), 32'(sb_e[IW+UW-1:UW]));
                    check("sb_uop", 32'(out_uop), 32'(sb_e[UW-1:0]));
                end
            end
            if (flush) sb.delete();
            else if (in_valid && in_ready) sb.push_back({in_imm, in_uop});
        end
    end

    task automatic apply(input vec_t v, input string tag);
        in_valid  = v.iv;
        in_imm    = IW'(v.imm);
        in_uop    = uop_of(IW'(v.imm));
        out_ready = v.rdy;
        flush     = v.fl;
        @(posedge clk);
        #1;
        check({tag, "_out_valid"}, 32'(out_valid), 32'(v.ov));
        check({tag, "_in_ready"}, 32'(in_ready), 32'(v.ir));
        check({tag, "_out_imm"}, 32'(out_imm), v.eimm);
        check({tag, "_out_uop"}, 32'(out_uop), 32'(uop_of(IW'(v.eimm))));
    endtask

    task automatic reset_pulse(input int cycles);
        rst_n    = 1'b0;
        in_valid = 1'b1;
        in_imm   = IW'(32'h77);
        in_uop   = uop_of(IW'(32'h77));
        flush    = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_imm", 32'(out_imm), 32'd0);
        check("rst_out_uop", 32'(out_uop), 32'd0);
        rst_n    = 1'b1;
        in_valid = 1'b0;
    endtask

    initial begin
        // streaming
        vecs[0]  = mk(1, 32'h1, 1, 0, 1, 1, 32'h1);
        vecs[1]  = mk(1, 32'h2, 1, 0, 1, 1, 32'h2);
        vecs[2]  = mk(1, 32'h3, 1, 0, 1, 1, 32'h3);
        vecs[3]  = mk(0, 32'h0, 1, 0, 0, 1, 32'h3);
        // back-pressure: C held upstream while FULL
        vecs[4]  = mk(1, 32'hA, 0, 0, 1, 1, 32'hA);
        vecs[5]  = mk(1, 32'hB, 0, 0, 1, 0, 32'hA);
        vecs[6]  = mk(1, 32'hC, 0, 0, 1, 0, 32'hA);
        vecs[7]  = mk(1, 32'hC, 1, 0, 1, 1, 32'hB);
        vecs[8]  = mk(1, 32'hC, 1, 0, 1, 1, 32'hC);
        vecs[9]  = mk(0, 32'h0, 1, 0, 0, 1, 32'hC);
        // simultaneous accept and retire in ONE
        vecs[10] = mk(1, 32'h4, 0, 0, 1, 1, 32'h4);
        vecs[11] = mk(1, 32'h5, 1, 0, 1, 1, 32'h5);
        // flush from FULL, then flush with in_valid while EMPTY
        vecs[12] = mk(1, 32'h6, 0, 0, 1, 0, 32'h5);
        vecs[13] = mk(1, 32'h7, 0, 1, 0, 1, 32'h5);
        vecs[14] = mk(1, 32'h8, 0, 1, 0, 1, 32'h5);
        vecs[15] = mk(0, 32'h0, 1, 0, 0, 1, 32'h5);
        // flush coinciding with a retire
        vecs[16] = mk(1, 32'h9, 0, 0, 1, 1, 32'h9);
        vecs[17] = mk(1, 32'h10, 1, 1, 0, 1, 32'h9);
        vecs[18] = mk(0, 32'h0, 1, 0, 0, 1, 32'h9);

        out_ready = 1'b0;
        reset_pulse(2);

        for (int i = 0; i < 19; i++) apply(vecs[i], $sformatf("vec%0d", i));

        // reset in the middle of a stall discards both entries
        apply(mk(1, 32'h11, 0, 0, 1, 1, 32'h11), "mid0");
        apply(mk(1, 32'h12, 0, 0, 1, 0, 32'h11), "mid1");
        reset_pulse(1);
        apply(mk(1, 32'h14, 0, 0, 1, 1, 32'h14), "mid2");
        apply(mk(0, 32'h0, 1, 0, 0, 1, 32'h14), "mid3");
        apply(mk(0, 32'h0, 1, 0, 0, 1, 32'h14), "mid4");

`ifdef RISCV_V_ISSUE_BUF_PERF_EN
        reset_pulse(1);
        check("perf_after_rst", stall_cnt, 32'd0);
        apply(mk(1, 32'h30, 0, 0, 1, 1, 32'h30), "perf_load");
        check("perf_load_cnt", stall_cnt, 32'd0);
        for (int i = 0; i < 7; i++) apply(mk(0, 32'h0, 0, 0, 1, 1, 32'h30), "perf_stall");
        check("perf_stall_cnt", stall_cnt, 32'd7);
        apply(mk(0, 32'h0, 1, 1, 0, 1, 32'h30), "perf_flush");
        check("perf_flush_cnt", stall_cnt, 32'd7);
        reset_pulse(1);
        check("perf_reset_cnt", stall_cnt, 32'd0);
`endif

        @(negedge clk);
        check("sb_drain", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
